// File: rtl/mips_muldiv_pkg.sv
// Shared encodings and defaults for the MIPS multiply/divide unit.
// Imported by the top and the sign-correction sub-module.
package mips_muldiv_pkg;

   localparam int MD_WIDTH = 32;
   localparam int MD_ITERS = 32;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX
   } md_state_e;

endpackage

// File: rtl/mips_muldiv_unit_sign_fix.sv
// Final sign correction of the unsigned iteration result.
// Produces the HI/LO values written at the end of an operation.
module muldiv_sign_fix
   import mips_muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic               is_div_i,
   input  logic               is_sgn_i,
   input  logic               neg_rs_i,
   input  logic               neg_rt_i,
   input  logic               div_zero_i,
   output logic [WIDTH-1:0]   hi_o,
   output logic [WIDTH-1:0]   lo_o
);

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic               neg_res;

   // Negate product/quotient/remainder according to operand signs
   always_comb begin
      neg_res = is_sgn_i & (neg_rs_i ^ neg_rt_i);
      prod    = neg_res ? -acc_i : acc_i;
      quo     = acc_i[WIDTH-1:0];
      rem     = acc_i[2*WIDTH-1:WIDTH];
      hi_o    = prod[2*WIDTH-1:WIDTH];
      lo_o    = prod[WIDTH-1:0];
      if (is_div_i) begin
         // rem is |rs| on a zero divisor, so this restores rs
         hi_o = (is_sgn_i & neg_rs_i) ? -rem : rem;
         if (div_zero_i)
            lo_o = {WIDTH{1'b1}};
         else
            lo_o = neg_res ? -quo : quo;
      end
   end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// One bit per cycle, then a single sign-fix cycle.
module mips_muldiv_unit
   import mips_muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int ITERS = MD_ITERS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             md_valid,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hilo_rd,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall
);

   localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

   md_state_e          state_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               busy_q;
   logic               is_div_q;
   logic               is_sgn_q;
   logic               neg_rs_q;
   logic               neg_rt_q;
   logic               dz_q;

   logic               req_md;
   logic               req_sgn;
   logic               req_div;
   logic               rs_neg;
   logic               rt_neg;
   logic [WIDTH-1:0]   rs_abs;
   logic [WIDTH-1:0]   rt_abs;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_diff;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   // Decode the request and form operand magnitudes
   always_comb begin
      req_md  = 1'b0;
      req_sgn = 1'b0;
      req_div = 1'b0;
      case (md_op)
         MD_MULT: begin
            req_md  = 1'b1;
            req_sgn = 1'b1;
         end
         MD_MULTU: req_md = 1'b1;
         MD_DIV: begin
            req_md  = 1'b1;
            req_sgn = 1'b1;
            req_div = 1'b1;
         end
         MD_DIVU: begin
            req_md  = 1'b1;
            req_div = 1'b1;
         end
         default: ;
      endcase
      rs_neg = req_sgn & rs_val[WIDTH-1];
      rt_neg = req_sgn & rt_val[WIDTH-1];
      // |0x80000000| wraps back to itself, read as unsigned magnitude
      rs_abs = rs_neg ? -rs_val : rs_val;
      rt_abs = rt_neg ? -rt_val : rt_val;
   end

   // One shift-add or restoring-divide step on the accumulator
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
      div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
      if (is_div_q) begin
         if (div_diff[WIDTH])
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
         else
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   muldiv_sign_fix #(
      .WIDTH(WIDTH)
   ) u_sign_fix (
      .acc_i      (acc_q),
      .is_div_i   (is_div_q),
      .is_sgn_i   (is_sgn_q),
      .neg_rs_i   (neg_rs_q),
      .neg_rt_i   (neg_rt_q),
      .div_zero_i (dz_q),
      .hi_o       (fix_hi),
      .lo_o       (fix_lo)
   );

   // Control FSM, iteration registers and HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         is_div_q <= 1'b0;
         is_sgn_q <= 1'b0;
         neg_rs_q <= 1'b0;
         neg_rt_q <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (md_valid && req_md) begin
                  acc_q    <= req_div ? {{WIDTH{1'b0}}, rs_abs}
                                      : {{WIDTH{1'b0}}, rt_abs};
                  opnd_q   <= req_div ? rt_abs : rs_abs;
                  is_div_q <= req_div;
                  is_sgn_q <= req_sgn;
                  neg_rs_q <= rs_neg;
                  neg_rt_q <= rt_neg;
                  dz_q     <= req_div & (rt_val == '0);
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_CALC;
               end else if (md_valid && md_op == MD_MTHI) begin
                  hi_q <= rs_val;
               end else if (md_valid && md_op == MD_MTLO) begin
                  lo_q <= rs_val;
               end
            end
            ST_CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST)
                  state_q <= ST_FIX;
            end
            ST_FIX: begin
               hi_q    <= fix_hi;
               lo_q    <= fix_lo;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign hi    = hi_q;
   assign lo    = lo_q;
   assign busy  = busy_q;
   assign stall = busy_q & (md_valid | hilo_rd);

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed-vector bench for mips_muldiv_unit.
// Expected values are hand-computed constants.
module tb_mips_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        md_valid;
   logic [2:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        hilo_rd;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mips_muldiv_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .md_valid (md_valid),
      .md_op    (md_op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .hilo_rd  (hilo_rd),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .stall    (stall)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // present one request for a single edge
   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge clk);
      md_valid = 1'b1;
      md_op    = op;
      rs_val   = a;
      rt_val   = b;
      @(posedge clk);
      #1;
      md_valid = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic run(input string tag, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el);
      int n;
      issue(op, a, b);
      check({tag, " busy"}, 32'(busy), 32'd1);
      wait_idle(n);
      check({tag, " lat"}, 32'(n), 32'd33);
      check({tag, " hi"}, hi, eh);
      check({tag, " lo"}, lo, el);
   endtask

   initial begin
      int n;
      rst_n    = 1'b0;
      md_valid = 1'b0;
      md_op    = 3'd0;
      rs_val   = '0;
      rt_val   = '0;
      hilo_rd  = 1'b0;
      #12;
      check("rst hi", hi, 32'h0);
      check("rst lo", lo, 32'h0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run("multu max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001);
      run("mult -3*5", 3'd0, 32'hFFFF_FFFD, 32'd5,
          32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run("divu /0", 3'd3, 32'd100, 32'd0,
          32'd100, 32'hFFFF_FFFF);
      run("div sgn /0", 3'd2, 32'hFFFF_FFF9, 32'd0,
          32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0, 32'h8000_0000);

      // MFHI/MFLO while busy is held until the result lands
      issue(3'd3, 32'd100, 32'd7);
      hilo_rd = 1'b1;
      #1;
      check("rd stall", 32'(stall), 32'd1);
      n = 0;
      while (stall && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rd stall len", 32'(n), 32'd33);
      check("rd lo", lo, 32'd14);
      check("rd hi", hi, 32'd2);
      hilo_rd = 1'b0;

      // second MULT waits behind the first
      issue(3'd0, 32'd6, 32'd7);
      md_valid = 1'b1;
      md_op    = 3'd0;
      rs_val   = 32'hFFFF_FFFE;
      rt_val   = 32'd3;
      #1;
      check("b2b stall", 32'(stall), 32'd1);
      wait_idle(n);
      check("b2b lat1", 32'(n), 32'd33);
      check("b2b lo1", lo, 32'd42);
      check("b2b hi1", hi, 32'd0);
      check("b2b free", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      md_valid = 1'b0;
      check("b2b acc2", 32'(busy), 32'd1);
      wait_idle(n);
      check("b2b lat2", 32'(n), 32'd33);
      check("b2b hi2", hi, 32'hFFFF_FFFF);
      check("b2b lo2", lo, 32'hFFFF_FFFA);

      // MTHI while idle
      @(negedge clk);
      md_valid = 1'b1;
      md_op    = 3'd4;
      rs_val   = 32'h1234;
      #1;
      check("mthi stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      md_valid = 1'b0;
      check("mthi hi", hi, 32'h1234);
      check("mthi lo", lo, 32'hFFFF_FFFA);
      check("mthi busy", 32'(busy), 32'd0);

      // reserved op is a no-op
      issue(3'd6, 32'h5555_5555, 32'h3);
      check("rsv hi", hi, 32'h1234);
      check("rsv lo", lo, 32'hFFFF_FFFA);
      check("rsv busy", 32'(busy), 32'd0);
      issue(3'd7, 32'h5555_5555, 32'h3);
      check("rsv7 busy", 32'(busy), 32'd0);

      // MTLO while busy is held, not applied early
      issue(3'd1, 32'd2, 32'd5);
      md_valid = 1'b1;
      md_op    = 3'd5;
      rs_val   = 32'hDEAD;
      repeat (10) @(posedge clk);
      #1;
      check("mtlo held", lo, 32'hFFFF_FFFA);
      check("mtlo stall", 32'(stall), 32'd1);
      wait_idle(n);
      check("mtlo lat", 32'(n), 32'd23);
      check("mtlo mul lo", lo, 32'd10);
      check("mtlo mul hi", hi, 32'd0);
      @(posedge clk);
      #1;
      md_valid = 1'b0;
      check("mtlo lo", lo, 32'hDEAD);
      check("mtlo busy", 32'(busy), 32'd0);

      // asynchronous reset in the middle of CALC
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      hilo_rd = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid rst hi", hi, 32'h0);
      check("mid rst lo", lo, 32'h0);
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      hilo_rd = 1'b0;
      run("post rst", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
